banner_overlay: RTL and testbench

- Parametrised, pipelined successor to the fixed per-message logo decoders: one block draws any 1-bpp text banner stored in an external synchronous ROM.
- Adds runtime display modes (off, static, blink, slide-in) driven by a per-frame tick.
- Sits between the VGA controller (DrawX/DrawY) and the colour mapper; one instance per banner (title, game over, press start, you win, boss).

---
 rtl/galaga_pkg.sv | 7 +
 rtl/banner_anim_ctrl.sv | 58 +++++
 rtl/banner_overlay.sv | 61 ++++++
 tb/tb_banner_overlay.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/galaga_pkg.sv
// galaga_pkg: shared banner overlay types and screen constants
package galaga_pkg;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   typedef enum logic [1:0] {MODE_OFF, MODE_STATIC, MODE_BLINK, MODE_SLIDE} overlay_mode_t;
   typedef enum logic [2:0] {IDLE, STATIC, BLINK_ON, BLINK_OFF, SLIDE, HOLD} banner_state_t;
endpackage

// File: rtl/banner_anim_ctrl.sv
// banner_anim_ctrl: display-mode FSM driving banner visibility and vertical slide position
module banner_anim_ctrl
   import galaga_pkg::*;
#(
   parameter int Y_POS        = 232,
   parameter int BLINK_FRAMES = 30,
   parameter int SLIDE_STEP   = 2
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [1:0] mode,
   output logic       vis,
   output logic [9:0] y_cur,
   output logic       anim_done
);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   banner_state_t state, state_n;
   overlay_mode_t m;
   logic [BW-1:0] blink_cnt, blink_cnt_n;
   logic [9:0] y_n;
   logic [10:0] y_step;
   logic blink_wrap;
   assign m = overlay_mode_t'(mode);
   assign vis = state inside {STATIC, HOLD, BLINK_ON, SLIDE};
   assign anim_done = state inside {STATIC, HOLD, BLINK_ON, BLINK_OFF};
   always_comb begin
      y_step = {1'b0, y_cur} + 11'(SLIDE_STEP);
      blink_wrap = blink_cnt == BW'(BLINK_FRAMES - 1);
      state_n = state;
      blink_cnt_n = blink_cnt;
      y_n = y_cur;
      if (start) begin
         blink_cnt_n = '0;
         y_n = m == MODE_SLIDE ? 10'd0 : 10'(Y_POS);
         state_n = m == MODE_STATIC ? STATIC : m == MODE_BLINK ? BLINK_ON : m == MODE_SLIDE ? SLIDE : IDLE;
      end else if (frame_tick && (state == BLINK_ON || state == BLINK_OFF)) begin
         blink_cnt_n = blink_wrap ? '0 : blink_cnt + BW'(1);
         state_n = !blink_wrap ? state : state == BLINK_ON ? BLINK_OFF : BLINK_ON;
      end else if (frame_tick && state == SLIDE) begin
         // saturate at the resting row so the banner never overshoots
         y_n = y_step >= 11'(Y_POS) ? 10'(Y_POS) : y_step[9:0];
         state_n = y_step >= 11'(Y_POS) ? HOLD : SLIDE;
      end
   end
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         blink_cnt <= '0;
         y_cur <= 10'(Y_POS);
      end else begin
         state <= state_n;
         blink_cnt <= blink_cnt_n;
         y_cur <= y_n;
      end
   end
endmodule

// File: rtl/banner_overlay.sv
// banner_overlay: 1-bpp ROM banner renderer with 2-cycle hit/ROM/pixel pipeline
module banner_overlay
   import galaga_pkg::*;
#(
   parameter int LOGO_W       = 96,
   parameter int LOGO_H       = 16,
   parameter int ROM_AW       = 4,
   parameter int X_POS        = 272,
   parameter int Y_POS        = 232,
   parameter int BLINK_FRAMES = 30,
   parameter int SLIDE_STEP   = 2
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              frame_tick,
   input  logic              start,
   input  logic [1:0]        mode,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [LOGO_W-1:0] rom_data,
   output logic              is_logo,
   output logic              anim_done
);
   localparam int CW = $clog2(LOGO_W);
   logic [9:0] y_cur;
   logic vis, hit, hit_q;
   logic [CW-1:0] col, col_q;
   banner_anim_ctrl #(
      .Y_POS(Y_POS),
      .BLINK_FRAMES(BLINK_FRAMES),
      .SLIDE_STEP(SLIDE_STEP)
   ) u_ctrl (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .frame_tick(frame_tick),
      .start(start),
      .mode(mode),
      .vis(vis),
      .y_cur(y_cur),
      .anim_done(anim_done)
   );
   // ROM stores the leftmost pixel in the MSB, so the column index is mirrored
   always_comb begin
      hit = {1'b0, DrawX} >= 11'(X_POS) && {1'b0, DrawX} < 11'(X_POS + LOGO_W)
         && {1'b0, DrawY} >= {1'b0, y_cur} && {1'b0, DrawY} < {1'b0, y_cur} + 11'(LOGO_H);
      rom_addr = hit ? ROM_AW'(DrawY - y_cur) : '0;
      col = hit ? CW'(11'(LOGO_W - 1) - ({1'b0, DrawX} - 11'(X_POS))) : '0;
   end
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hit_q <= 1'b0;
         col_q <= '0;
         is_logo <= 1'b0;
      end else begin
         hit_q <= hit;
         col_q <= col;
         is_logo <= hit_q & vis & rom_data[col_q];
      end
   end
endmodule

// File: tb/tb_banner_overlay.sv
// tb_banner_overlay: vector, random-stream and animation checks against a behavioural banner model
module tb_banner_overlay;
   logic Clk = 0, Reset_n = 0, frame_tick = 0, start = 0;
   logic [1:0] mode = 0;
   logic [9:0] DrawX = 0, DrawY = 0;
   logic [3:0] addr_a, addr_b;
   logic [2:0] addr_c;
   logic [95:0] rd_a, rd_b;
   logic [55:0] rd_c;
   logic logo_a, logo_b, logo_c, done_a, done_b, done_c;
   logic [95:0] rom_a [16];
   logic [55:0] rom_c [8];
   logic exq[$], exq_b[$];
   int n_chk = 0, n_fail = 0;

   typedef struct { int x; int y; logic exp; } vec_t;
   vec_t vecs[8];

   always #5 Clk = ~Clk;
   always_ff @(posedge Clk) begin
      rd_a <= rom_a[addr_a];
      rd_b <= rom_a[addr_b];
      rd_c <= rom_c[addr_c];
   end

   banner_overlay dut_a (.Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .frame_tick(frame_tick),
      .start(start), .mode(mode), .rom_addr(addr_a), .rom_data(rd_a), .is_logo(logo_a), .anim_done(done_a));
   banner_overlay #(.SLIDE_STEP(5)) dut_b (.Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .frame_tick(frame_tick), .start(start), .mode(mode), .rom_addr(addr_b), .rom_data(rd_b), .is_logo(logo_b),
      .anim_done(done_b));
   banner_overlay #(.LOGO_W(56), .LOGO_H(6), .ROM_AW(3), .X_POS(293), .Y_POS(253)) dut_c (.Clk(Clk),
      .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .frame_tick(frame_tick), .start(start), .mode(mode),
      .rom_addr(addr_c), .rom_data(rd_c), .is_logo(logo_c), .anim_done(done_c));

   function automatic logic model_a(int x, int y, int yc, logic v);
      if (!v || x < 272 || x >= 368 || y < yc || y >= yc + 16) return 1'b0;
      return rom_a[y - yc][95 - (x - 272)];
   endfunction

   function automatic logic model_c(int x, int y);
      if (x < 293 || x >= 349 || y < 253 || y >= 259) return 1'b0;
      return rom_c[y - 253][55 - (x - 293)];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1;
      step();
      frame_tick = 0;
   endtask

   task automatic go(input logic [1:0] m);
      mode = m;
      start = 1;
      step();
      start = 0;
   endtask

   task automatic pix(input int x, input int y);
      DrawX = 10'(x);
      DrawY = 10'(y);
      step();
      step();
   endtask

   initial begin
      for (int r = 0; r < 16; r++) rom_a[r] = {$urandom, $urandom, $urandom};
      for (int r = 0; r < 8; r++) rom_c[r] = r < 6 ? 56'({$urandom, $urandom}) : '1;
      rom_a[0] = '1;
      rom_a[15][0] = 1'b1;
      rom_a[3][85] = 1'b0;
      rom_a[8][67] = 1'b1;
      vecs[0] = '{272, 232, 1'b1};
      vecs[1] = '{271, 232, 1'b0};
      vecs[2] = '{368, 232, 1'b0};
      vecs[3] = '{367, 247, 1'b1};
      vecs[4] = '{367, 248, 1'b0};
      vecs[5] = '{272, 231, 1'b0};
      vecs[6] = '{282, 235, 1'b0};
      vecs[7] = '{300, 240, 1'b1};

      repeat (3) @(posedge Clk);
      #1;
      check("rst_logo", logo_a, 0);
      check("rst_done", done_a, 0);
      check("rst_ycur", dut_a.y_cur, 232);
      Reset_n = 1;
      pix(272, 232);
      step();
      check("idle_logo", logo_a, 0);
      check("idle_done", done_a, 0);

      go(2'b01);
      check("static_done", done_a, 1);
      pix(0, 0);
      DrawX = 272; DrawY = 237; #1;
      check("addr_row5", addr_a, 5);
      DrawX = 400; #1;
      check("addr_miss", addr_a, 0);
      DrawX = 272; DrawY = 232; #1;
      check("addr_row0", addr_a, 0);
      step();
      DrawX = 0; DrawY = 0;
      check("lat_n1", logo_a, 0);
      step();
      check("lat_n2", logo_a, 1);
      step();
      check("lat_n3", logo_a, 0);

      for (int i = 0; i < 8; i++) begin
         pix(vecs[i].x, vecs[i].y);
         check($sformatf("vec%0d", i), logo_a, vecs[i].exp);
      end

      for (int i = 0; i < 302; i++) begin
         if (i >= 2) begin
            check("rand_a", logo_a, exq.pop_front());
            check("rand_b", logo_b, exq_b.pop_front());
         end
         if (i < 300) begin
            int x, y;
            x = $urandom_range(390, 250);
            y = $urandom_range(260, 220);
            DrawX = 10'(x); DrawY = 10'(y);
            exq.push_back(model_a(x, y, 232, 1'b1));
            exq_b.push_back(model_a(x, y, 232, 1'b1));
         end
         step();
      end

      for (int i = 0; i < 72 * 14 + 2; i++) begin
         if (i >= 2) check("map_c", logo_c, exq.pop_front());
         if (i < 72 * 14) begin
            DrawX = 10'(285 + i % 72);
            DrawY = 10'(249 + i / 72);
            exq.push_back(model_c(285 + i % 72, 249 + i / 72));
         end
         step();
      end
      check("static_done_c", done_c, 1);

      go(2'b00);
      check("off_done", done_a, 0);
      pix(272, 232);
      check("off_logo", logo_a, 0);

      go(2'b10);
      pix(300, 240);
      check("blink_k0", logo_a, 1);
      for (int k = 1; k <= 60; k++) begin
         tick();
         step();
         step();
         check($sformatf("blink_k%0d", k), logo_a, ((k / 30) % 2 == 0) ? 1 : 0);
         check("blink_done", done_a, 1);
      end

      go(2'b11);
      check("slide_y0", dut_a.y_cur, 0);
      check("slide_done0", done_a, 0);
      for (int k = 1; k <= 120; k++) begin
         tick();
         check($sformatf("slide_a_y%0d", k), dut_a.y_cur, (2 * k < 232) ? 2 * k : 232);
         check("slide_a_done", done_a, (2 * k >= 232) ? 1 : 0);
         check($sformatf("slide_b_y%0d", k), dut_b.y_cur, (5 * k < 232) ? 5 * k : 232);
         check("slide_b_done", done_b, (5 * k >= 232) ? 1 : 0);
      end

      go(2'b11);
      repeat (50) tick();
      check("pre_coll_y", dut_a.y_cur, 100);
      mode = 2'b11; start = 1; frame_tick = 1;
      step();
      start = 0; frame_tick = 0;
      check("coll_y", dut_a.y_cur, 0);
      repeat (25) tick();
      pix(272, 50);
      check("slide_logo50", logo_a, 1);
      #2 Reset_n = 0;
      #1;
      check("arst_slide_logo", logo_a, 0);
      check("arst_slide_done", done_a, 0);
      check("arst_slide_y", dut_a.y_cur, 232);
      @(negedge Clk) Reset_n = 1;
      step();

      go(2'b01);
      pix(272, 232);
      check("pre_arst_logo", logo_a, 1);
      check("pre_arst_done", done_a, 1);
      #2 Reset_n = 0;
      #1;
      check("arst_logo", logo_a, 0);
      check("arst_done", done_a, 0);
      @(negedge Clk) Reset_n = 1;
      step();
      tick();
      tick();
      pix(272, 232);
      check("post_rst_logo", logo_a, 0);
      check("post_rst_done", done_a, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
